// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with stall, bubble, flush
// and saturating stall/bubble performance counters.
module pipe_stage_reg #(
  parameter int DATA_W      = 106,
  parameter int WE_W        = 5,
  parameter int INST_W      = 32,
  parameter int STALL_W     = 6,
  parameter int UP_IDX      = 4,
  parameter bit ZERO_BUBBLE = 1'b1,
  parameter int CNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic               in_valid,
  input  logic [WE_W-1:0]    in_we,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [INST_W-1:0]  in_inst,
  input  logic               cnt_clr,
  output logic               out_valid,
  output logic [WE_W-1:0]    out_we,
  output logic [DATA_W-1:0]  out_data,
  output logic [INST_W-1:0]  out_inst,
  output logic [CNT_W-1:0]   bubble_cnt,
  output logic [CNT_W-1:0]   hold_cnt
);

  localparam int DN_IDX = UP_IDX + 1;

  typedef enum logic [2:0] {
    ACT_RST,
    ACT_FLUSH,
    ACT_BUBBLE,
    ACT_LOAD,
    ACT_HOLD
  } act_e;

  logic up_stop;
  logic dn_stop;

  generate
    if (DN_IDX >= STALL_W) begin : g_bad_idx
      $error("pipe_stage_reg: UP_IDX+1 must be below STALL_W");
      assign up_stop = 1'b0;
      assign dn_stop = 1'b0;
    end else begin : g_idx
      assign up_stop = stall[UP_IDX];
      assign dn_stop = stall[DN_IDX];
    end
  endgenerate

  act_e act;

  always_comb begin
    act = ACT_LOAD;
    if (rst)
      act = ACT_RST;
    else if (flush)
      act = ACT_FLUSH;
    else if (up_stop && !dn_stop)
      act = ACT_BUBBLE;
    else if (up_stop)
      act = ACT_HOLD;
  end

  logic              valid_d;
  logic [WE_W-1:0]   we_d;
  logic [DATA_W-1:0] data_d;
  logic [INST_W-1:0] inst_d;

  always_comb begin
    valid_d = out_valid;
    we_d    = out_we;
    data_d  = out_data;
    inst_d  = out_inst;
    unique case (act)
      ACT_RST, ACT_FLUSH: begin
        valid_d = 1'b0;
        we_d    = '0;
        data_d  = '0;
        inst_d  = '0;
      end
      ACT_BUBBLE: begin
        valid_d = 1'b0;
        we_d    = '0;
        inst_d  = in_inst;
        if (ZERO_BUBBLE)
          data_d = '0;
      end
      ACT_LOAD: begin
        valid_d = in_valid;
        // a non-valid slot must never write back
        we_d    = in_valid ? in_we : '0;
        data_d  = in_data;
        inst_d  = in_inst;
      end
      ACT_HOLD: begin
        valid_d = out_valid;
      end
      default: begin
        valid_d = 1'b0;
        we_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    out_valid <= valid_d;
    out_we    <= we_d;
    out_data  <= data_d;
    out_inst  <= inst_d;
  end

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic bub_inc;
  logic hold_inc;

  assign bub_inc  = (act == ACT_BUBBLE);
  assign hold_inc = (act == ACT_HOLD);

  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      bubble_cnt <= '0;
      hold_cnt   <= '0;
    end else begin
      if (bub_inc && bubble_cnt != CNT_MAX)
        bubble_cnt <= bubble_cnt + 1'b1;
      if (hold_inc && hold_cnt != CNT_MAX)
        hold_cnt <= hold_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: default, held-bubble and
// narrow-counter instances share one stimulus stream.
module tb_pipe_stage_reg;

  logic         clk = 1'b0;
  logic         rst;
  logic [5:0]   stall;
  logic         flush;
  logic         in_valid;
  logic [4:0]   in_we;
  logic [105:0] in_data;
  logic [31:0]  in_inst;
  logic         cnt_clr;

  logic         v0, v1, v2;
  logic [4:0]   we0, we1, we2;
  logic [105:0] d0, d1, d2;
  logic [31:0]  i0, i1, i2;
  logic [15:0]  bc0, hc0, bc1, hc1;
  logic [1:0]   bc2, hc2;

  int total = 0;
  int bad   = 0;

  localparam logic [105:0] VA = 106'h1234_5678_9ABC;
  localparam logic [105:0] VB = 106'h2_0000_0000_0055;

  always #5 clk = ~clk;

  pipe_stage_reg u0 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_we(in_we), .in_data(in_data),
    .in_inst(in_inst), .cnt_clr(cnt_clr),
    .out_valid(v0), .out_we(we0), .out_data(d0), .out_inst(i0),
    .bubble_cnt(bc0), .hold_cnt(hc0)
  );

  pipe_stage_reg #(.ZERO_BUBBLE(1'b0)) u1 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_we(in_we), .in_data(in_data),
    .in_inst(in_inst), .cnt_clr(cnt_clr),
    .out_valid(v1), .out_we(we1), .out_data(d1), .out_inst(i1),
    .bubble_cnt(bc1), .hold_cnt(hc1)
  );

  pipe_stage_reg #(.CNT_W(2)) u2 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_we(in_we), .in_data(in_data),
    .in_inst(in_inst), .cnt_clr(cnt_clr),
    .out_valid(v2), .out_we(we2), .out_data(d2), .out_inst(i2),
    .bubble_cnt(bc2), .hold_cnt(hc2)
  );

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    stall = 6'b0;
    flush = 1'b0;
    cnt_clr = 1'b0;
    in_valid = 1'b1;
    in_we = 5'h1F;
    in_data = '1;
    in_inst = 32'hFFFF_FFFF;
    step();
    step();
    chk("rst_valid", v0, 0);
    chk("rst_we", we0, 0);
    chk("rst_data", d0, 0);
    chk("rst_inst", i0, 0);
    chk("rst_bcnt", bc0, 0);
    chk("rst_hcnt", hc0, 0);

    rst = 1'b0;
    in_we = 5'b00001;
    in_data = 106'h3_DEAD_BEEF;
    in_inst = 32'h3C01_0001;
    step();
    chk("ld_valid", v0, 1);
    chk("ld_we", we0, 5'b00001);
    chk("ld_data", d0, 106'h3_DEAD_BEEF);
    chk("ld_inst", i0, 32'h3C01_0001);

    stall = 6'b011111;
    in_data = '1;
    for (int k = 0; k < 3; k++) begin
      in_inst = 32'h100 + k;
      step();
      chk("bub_inst", i0, 32'h100 + k);
    end
    chk("bub_valid", v0, 0);
    chk("bub_we", we0, 0);
    chk("bub_data0", d0, 0);
    chk("bub_cnt", bc0, 3);
    chk("bub_hold_data", d1, 106'h3_DEAD_BEEF);
    chk("bub_hold_valid", v1, 0);
    chk("bub_hold_we", we1, 0);
    chk("bub_cnt1", bc1, 3);

    stall = 6'b0;
    in_we = 5'b10101;
    in_data = VA;
    in_inst = 32'hAAAA_AAAA;
    step();
    stall = 6'b111111;
    in_we = 5'b01010;
    in_data = VB;
    in_inst = 32'h5555_5555;
    for (int k = 0; k < 4; k++) step();
    chk("hold_data", d0, VA);
    chk("hold_we", we0, 5'b10101);
    chk("hold_valid", v0, 1);
    chk("hold_inst", i0, 32'hAAAA_AAAA);
    chk("hold_cnt", hc0, 4);
    chk("hold_sat4", hc2, 3);
    step();
    chk("hold_cnt5", hc0, 5);
    chk("hold_sat5", hc2, 3);
    chk("hold_bcnt", bc0, 3);

    stall = 6'b0;
    step();
    chk("rel_data", d0, VB);
    chk("rel_we", we0, 5'b01010);

    stall = 6'b111111;
    cnt_clr = 1'b1;
    step();
    chk("clr_hcnt", hc0, 0);
    chk("clr_hcnt2", hc2, 0);
    chk("clr_bcnt", bc0, 0);
    cnt_clr = 1'b0;

    stall = 6'b011111;
    step();
    chk("bub1_cnt", bc0, 1);
    stall = 6'b0;
    in_data = VA;
    step();
    stall = 6'b011111;
    flush = 1'b1;
    in_inst = 32'h1234_0000;
    step();
    chk("fl_inst", i0, 0);
    chk("fl_valid", v0, 0);
    chk("fl_data", d0, 0);
    chk("fl_we", we0, 0);
    chk("fl_bcnt", bc0, 1);
    chk("fl_data1", d1, 0);
    flush = 1'b0;

    stall = 6'b0;
    in_valid = 1'b0;
    in_we = 5'h1F;
    in_data = 106'h77;
    step();
    chk("inv_we", we0, 0);
    chk("inv_valid", v0, 0);
    chk("inv_data", d0, 106'h77);

    stall = 6'b100000;
    in_valid = 1'b1;
    in_we = 5'b00011;
    in_data = 106'h99;
    in_inst = 32'hCAFE_0001;
    step();
    chk("dn_valid", v0, 1);
    chk("dn_we", we0, 5'b00011);
    chk("dn_data", d0, 106'h99);
    chk("dn_inst", i0, 32'hCAFE_0001);

    stall = 6'b111111;
    step();
    rst = 1'b1;
    step();
    chk("mrst_valid", v0, 0);
    chk("mrst_data", d0, 0);
    chk("mrst_hcnt", hc0, 0);
    rst = 1'b0;
    stall = 6'b0;
    in_data = 106'h42;
    in_inst = 32'h0000_0042;
    step();
    chk("post_valid", v0, 1);
    chk("post_data", d0, 106'h42);
    chk("post_inst", i0, 32'h42);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
